// File: rtl/if_id_stage_if.sv
// Bundle between the fetch/decode control side and the IF/ID stage.
// The stage itself connects through the slave modport.
interface if_id_stage_if;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        ext_stall;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        stall_if;
  logic        id_bubble;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc8;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [31:0] id_imm_ext;
  logic [31:0] stall_count;

  modport master (
    output if_pc, if_instr, ext_stall, flush, ex_mem_read, ex_rt,
    input  stall_if, id_bubble, id_valid, id_pc, id_instr, id_pc8,
           id_rs, id_rt, id_rd, id_shamt, id_imm_ext, stall_count
  );

  modport slave (
    input  if_pc, if_instr, ext_stall, flush, ex_mem_read, ex_rt,
    output stall_if, id_bubble, id_valid, id_pc, id_instr, id_pc8,
           id_rs, id_rt, id_rd, id_shamt, id_imm_ext, stall_count
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: field decode, load-use hazard detection, stall and flush control.
// Defining IF_ID_STALL_CNT_EN builds a saturating counter of load-use bubble cycles.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  if_id_stage_if.slave bus
);

  logic [31:0] idPc;
  logic [31:0] idInstr;
  logic        idValid;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rsField;
  logic [4:0]  rtField;
  logic [15:0] imm16;

  logic        usesRs;
  logic        usesRt;
  logic        rsMatch;
  logic        rtMatch;
  logic        hazard;
  logic        bubble;
  logic [31:0] immExt;

  assign opcode  = idInstr[31:26];
  assign rsField = idInstr[25:21];
  assign rtField = idInstr[20:16];
  assign funct   = idInstr[5:0];
  assign imm16   = idInstr[15:0];

  always_comb begin
    usesRs = 1'b1;
    case (opcode)
      6'h02, 6'h03, 6'h0F: usesRs = 1'b0;
      6'h00: begin
        if (funct == 6'h00 || funct == 6'h02 || funct == 6'h03)
          usesRs = 1'b0;
      end
      default: usesRs = 1'b1;
    endcase
  end

  always_comb begin
    usesRt = 1'b0;
    case (opcode)
      6'h00, 6'h04, 6'h05, 6'h2B: usesRt = 1'b1;
      default:                    usesRt = 1'b0;
    endcase
  end

  always_comb begin
    immExt = {{16{imm16[15]}}, imm16};
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: immExt = {16'h0000, imm16};
      6'h0F:               immExt = {imm16, 16'h0000};
      default:             immExt = {{16{imm16[15]}}, imm16};
    endcase
  end

  // $zero is never a real dependency, and an empty stage has nothing to protect.
  assign rsMatch = usesRs && (bus.ex_rt == rsField);
  assign rtMatch = usesRt && (bus.ex_rt == rtField);
  assign hazard  = idValid && bus.ex_mem_read && (bus.ex_rt != 5'd0) && (rsMatch || rtMatch);
  assign bubble  = !bus.flush && hazard && !bus.ext_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idPc    <= RESET_PC;
      idInstr <= NOP_INSTR;
      idValid <= 1'b0;
    end else if (bus.flush) begin
      idPc    <= bus.if_pc;
      idInstr <= NOP_INSTR;
      idValid <= 1'b0;
    end else if (!(hazard || bus.ext_stall)) begin
      idPc    <= bus.if_pc;
      idInstr <= bus.if_instr;
      idValid <= 1'b1;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= 32'h0000_0000;
    end else if (bubble && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign bus.stall_count = stallCnt;
`else
  assign bus.stall_count = 32'h0000_0000;
`endif

  assign bus.stall_if   = !bus.flush && (hazard || bus.ext_stall);
  assign bus.id_bubble  = bubble;
  assign bus.id_valid   = idValid;
  assign bus.id_pc      = idPc;
  assign bus.id_instr   = idInstr;
  assign bus.id_pc8     = idPc + 32'd8;
  assign bus.id_rs      = rsField;
  assign bus.id_rt      = rtField;
  assign bus.id_rd      = idInstr[15:11];
  assign bus.id_shamt   = idInstr[10:6];
  assign bus.id_imm_ext = immExt;

endmodule
